// File: rtl/char_catcher_pkg.sv
// Shared widths, defaults and the slot record for the falling-character catcher.
package char_catcher_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned SPD_W = 4;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 10;

  localparam int unsigned DEF_SLOTS   = 8;
  localparam int unsigned DEF_X_LIMIT = 480;

  // One on-screen character: x is the row, y the column.
  typedef struct packed {
    logic             active;
    logic [CH_W-1:0]  ch;
    logic [SPD_W-1:0] speed;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
  } slot_t;

endpackage

// File: rtl/char_catcher_pick.sv
// Priority selector: among requesting entries, picks the one with the largest
// key; ties resolve to the lowest index. With a constant key it degenerates to
// a plain lowest-index priority encoder.
module slot_pick #(
  parameter int unsigned N     = 8,
  parameter int unsigned KEY_W = 1,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]       req,
  input  logic [N*KEY_W-1:0] key,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [KEY_W-1:0] best;
  logic [KEY_W-1:0] cur;

  // Linear scan; strict greater-than keeps the earliest index on ties.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    cur   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cur = key[i*KEY_W +: KEY_W];
      if (req[i] && (!found || (cur > best))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        best  = cur;
      end
    end
  end

endmodule

// File: rtl/char_catcher.sv
// Slot pool for falling characters: spawn into free slots, advance on frame
// ticks, remove on key match (hit) or bottom crossing (miss).
module char_catcher
  import char_catcher_pkg::*;
#(
  parameter int unsigned SLOTS   = DEF_SLOTS,
  parameter int unsigned X_LIMIT = DEF_X_LIMIT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     spawn_valid,
  output logic                     spawn_ready,
  input  logic [7:0]               spawn_ch,
  input  logic [3:0]               spawn_speed,
  input  logic [8:0]               spawn_x,
  input  logic [9:0]               spawn_y,
  input  logic                     frame_tick,
  input  logic                     key_valid,
  input  logic [7:0]               key_ch,
  output logic                     hit,
  output logic                     wrong_key,
  output logic                     miss,
  output logic [15:0]              score,
  output logic [7:0]               misses,
  output logic [SLOTS-1:0]         active_mask,
  input  logic [$clog2(SLOTS)-1:0] rd_idx,
  output logic [7:0]               rd_ch,
  output logic [8:0]               rd_x,
  output logic [9:0]               rd_y
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(SLOTS + 1);
  localparam int unsigned MS_W  = 9 + CNT_W;
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(X_LIMIT);

  slot_t slot_q [SLOTS];
  slot_t slot_d [SLOTS];

  logic [15:0] score_q, score_d;
  logic [7:0]  misses_q, misses_d;
  logic        hit_q, wrong_q, miss_q;

  logic [SLOTS-1:0]     free_vec;
  logic [SLOTS-1:0]     match_vec;
  logic [SLOTS*X_W-1:0] match_key;
  logic                 free_found, match_found;
  logic [IDX_W-1:0]     free_idx, match_idx;

  logic             key_hit;
  logic             spawn_fire;
  logic [CNT_W-1:0] miss_cnt;
  logic [MS_W-1:0]  miss_sum;
  logic [X_W:0]     x_new;

  // Per-slot views of the registered state feeding the selectors.
  always_comb begin
    active_mask = '0;
    match_vec   = '0;
    match_key   = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      active_mask[i]             = slot_q[i].active;
      match_vec[i]               = slot_q[i].active && (slot_q[i].ch == key_ch);
      match_key[i*X_W +: X_W]    = slot_q[i].x;
    end
  end

  assign free_vec    = ~active_mask;
  assign spawn_ready = |free_vec;

  slot_pick #(
    .N     (SLOTS),
    .KEY_W (1),
    .IDX_W (IDX_W)
  ) u_free_pick (
    .req   (free_vec),
    .key   ('0),
    .found (free_found),
    .idx   (free_idx)
  );

  slot_pick #(
    .N     (SLOTS),
    .KEY_W (X_W),
    .IDX_W (IDX_W)
  ) u_match_pick (
    .req   (match_vec),
    .key   (match_key),
    .found (match_found),
    .idx   (match_idx)
  );

  assign key_hit    = key_valid && match_found;
  assign spawn_fire = spawn_valid && spawn_ready && free_found;

  // Next-state: key removal, then tick advance on the survivors, then spawn into
  // a slot that was already free, so the three never touch the same slot.
  always_comb begin
    for (int unsigned i = 0; i < SLOTS; i++) begin
      slot_d[i] = slot_q[i];
    end
    miss_cnt = '0;
    x_new    = '0;

    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (key_hit && (match_idx == IDX_W'(i))) begin
        slot_d[i].active = 1'b0;
      end else if (frame_tick && slot_q[i].active) begin
        x_new = (X_W + 1)'(slot_q[i].x) + (X_W + 1)'(slot_q[i].speed);
        if (x_new >= X_LIM) begin
          slot_d[i].active = 1'b0;
          miss_cnt         = miss_cnt + CNT_W'(1);
        end else begin
          slot_d[i].x = x_new[X_W-1:0];
        end
      end
    end

    if (spawn_fire) begin
      slot_d[free_idx] = '{active: 1'b1, ch: spawn_ch, speed: spawn_speed,
                           x: spawn_x, y: spawn_y};
    end
  end

  // Saturating score and miss counters.
  always_comb begin
    score_d  = score_q;
    misses_d = misses_q;
    miss_sum = MS_W'(misses_q) + MS_W'(miss_cnt);
    if (key_hit && (score_q != 16'hFFFF)) begin
      score_d = score_q + 16'd1;
    end
    if (miss_sum > MS_W'(8'hFF)) begin
      misses_d = 8'hFF;
    end else begin
      misses_d = miss_sum[7:0];
    end
  end

  // Register slot pool, counters and single-cycle event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      score_q  <= '0;
      misses_q <= '0;
      hit_q    <= 1'b0;
      wrong_q  <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      score_q  <= score_d;
      misses_q <= misses_d;
      hit_q    <= key_hit;
      wrong_q  <= key_valid && !match_found;
      miss_q   <= (miss_cnt != '0);
    end
  end

  assign hit       = hit_q;
  assign wrong_key = wrong_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign misses    = misses_q;

  assign rd_ch = slot_q[rd_idx].ch;
  assign rd_x  = slot_q[rd_idx].x;
  assign rd_y  = slot_q[rd_idx].y;

endmodule

// File: doc/char_catcher.md
# char_catcher

Consumer side of the falling-character generator. Accepts spawned characters (ch, speed, x, y) into a fixed pool of slots, moves them down the screen once per frame tick, and removes them when a keyboard character matches (hit) or when they pass the bottom edge (miss). Score and miss counters, plus a per-slot read port, feed the VGA renderer and the score display.

## Interface
Parameters:
- SLOTS, 8: number of simultaneously active characters.
- X_LIMIT, 480: vertical bottom edge. x is the row, y is the column, matching the generator.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- spawn_valid  in  1  generator offers a character.
- spawn_ready  out  1  at least one slot is free.
- spawn_ch  in  8  ASCII code.
- spawn_speed  in  4  rows advanced per frame tick.
- spawn_x  in  9  start row.
- spawn_y  in  10  column, 0..639.
- frame_tick  in  1  one-cycle pulse per video frame.
- key_valid  in  1  one-cycle pulse, decoded key available.
- key_ch  in  8  ASCII of pressed key.
- hit  out  1  one-cycle pulse, key removed a character.
- wrong_key  out  1  one-cycle pulse, key matched nothing.
- miss  out  1  one-cycle pulse, one or more characters passed bottom.
- score  out  16  hit count, saturating at 65535.
- misses  out  8  miss count, saturating at 255.
- active_mask  out  SLOTS  per-slot valid bits.
- rd_idx  in  log2(SLOTS)  renderer slot select.
- rd_ch, rd_x, rd_y  out  8/9/10  combinational read of slot rd_idx. Contents are don't-care when the slot is inactive.

## Operation
- Reset: all slots inactive. hit, wrong_key, miss, score, misses = 0. spawn_ready = 1.
- Spawn: the handshake completes when spawn_valid && spawn_ready. The character goes into the lowest-index slot that was free at the start of the cycle. spawn_ready is combinational: it is the OR of the inverted active_mask. Slots freed in the same cycle are not reusable until the next cycle.
- Key: on key_valid, the candidates are active slots with ch == key_ch.
  - Pick the candidate with the largest x (closest to the bottom). On a tie, pick the lowest index.
  - Clear the picked slot, pulse hit, and add 1 to score.
  - With no candidate, pulse wrong_key. State is unchanged.
- Frame tick: every active slot not removed by a key this cycle computes x_new = x + speed using 10-bit arithmetic.
  - If x_new >= X_LIMIT, clear the slot.
  - Otherwise x <= x_new.
  - If any slot is cleared by the bottom edge, pulse miss and add the number of cleared slots to misses, saturating.
- speed 0 is legal: the character never moves.
- A spawn with spawn_x >= X_LIMIT is accepted. It is removed as a miss on the next frame tick.
- Evaluation order within one cycle, all against the start-of-cycle state: key match first, then frame-tick advance, then spawn. A slot hit by a key in the same cycle as a bottom crossing counts as a hit, not a miss.
- Event types are independent. Spawn, key, and tick in the same cycle are all processed.

## Timing
- Single clock domain. All state is registered.
- Latency for key, tick, and spawn is 1 cycle. An event at cycle n shows its effect (slot contents, active_mask, pulses, counters) from cycle n+1.
- hit, wrong_key, and miss are high for exactly one cycle per triggering event.
- rd_* are zero-latency combinational reads of the registered slot state.
- Reset assertion at any time clears all state asynchronously. Operation restarts with an empty pool on the first clock after deassertion.

## Structure
- Shared package holds:
  - widths CH_W=8, SPD_W=4, X_W=9, Y_W=10;
  - defaults SLOTS and X_LIMIT;
  - the slot record type {active, ch, speed, x, y}.
- Sub-module slot_pick: a parameterized priority selector reused twice.
  - Instance 1 picks the lowest free index.
  - Instance 2 picks the match with the largest x, ties to the lowest index.
  - Outputs are found and idx.

## Test plan
- Reset, then spawn 'A' (0x41) with speed 4, x 0, y 100. After 10 frame ticks: rd_x = 40, active_mask = 0x01, no pulses.
- Fill all 8 slots: spawn_ready drops to 0 after the 8th handshake. Key on slot 3's char: hit at n+1, spawn_ready = 1 at n+1, and the next spawn lands in slot 3.
- Two 'B' chars at x=100 (slot 0) and x=200 (slot 5). Key 'B': slot 5 cleared, score = 1. Key 'B' again: slot 0 cleared, score = 2. Third key 'B': wrong_key, score stays 2.
- Char at x=476 with speed 4, frame tick: miss pulse, misses = 1, slot inactive. Repeat with key_valid on the same char in the same cycle as the tick: hit, score +1, misses unchanged.
- Three slots crossing the bottom on one tick: a single miss pulse, misses += 3. Preload misses to 254: result saturates at 255.
- Assert rst_n low mid-operation with 5 active slots: active_mask = 0, score = 0, misses = 0 immediately, without waiting for a clock edge.
